wb_master_cmd_engine: RTL



---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_ack_timer.sv | 36 +++
 rtl/wb_master_cmd_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone command engine.
package wb_pkg;

  // Engine states: waiting for a command, running a bus cycle, holding a response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int          WB_ADDRWIDTH_DEF = 7;
  localparam int          WB_DATAWIDTH_DEF = 32;
  localparam logic [31:0] WB_ERR_DAT_DEF   = 32'hDEAD_BEEF;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Cycle counter that watches a bus cycle and flags when the ACK wait has run out.
module wb_ack_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] count_q, count_d;

  // Load restarts the wait at zero; enable advances it by one bus cycle.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry lands on the last permitted BUS cycle so the cycle is aborted after exactly TIMEOUT_CYCLES.
  assign expire_o = (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_master_cmd_engine.sv
// Single-outstanding Wishbone initiator: valid/ready command in, bus cycle out, valid/ready response back.
module wb_master_cmd_engine
  import wb_pkg::*;
#(
  parameter int                   ADDRWIDTH      = WB_ADDRWIDTH_DEF,
  parameter int                   DATAWIDTH      = WB_DATAWIDTH_DEF,
  parameter int                   TIMEOUT_CYCLES = 16,
  parameter logic [DATAWIDTH-1:0] ERR_DAT_VALUE  = DATAWIDTH'(WB_ERR_DAT_DEF)
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_byte_stb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic                 busy_o,
  output logic [7:0]           err_cnt_o
);

  wb_state_e            state_q, state_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH-1:0] wdat_q, wdat_d;
  logic [3:0]           sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 cyc_q, cyc_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 timer_load, timer_en, timer_expire;

  wb_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk     (WBs_CLK_i),
    .srst    (WBs_RST_i),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .expire_o(timer_expire)
  );

  // Next-state and next-output decode; ACK is checked before the timeout so a last-cycle ACK still succeeds.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d      = cmd_adr_i;
          wdat_d     = cmd_dat_i;
          sel_d      = cmd_byte_stb_i;
          we_d       = cmd_we_i;
          cyc_d      = 1'b1;
          timer_load = 1'b1;
          state_d    = BUS;
        end
      end
      BUS: begin
        if (WBm_ACK_i) begin
          rsp_dat_d   = we_q ? '0 : WBm_DAT_i;
          rsp_err_d   = 1'b0;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_expire) begin
          rsp_dat_d   = ERR_DAT_VALUE;
          rsp_err_d   = 1'b1;
          err_cnt_d   = sat_inc8(err_cnt_q);
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset drops the bus and discards any pending response.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign WBm_ADR_o      = adr_q;
  assign WBm_DAT_o      = wdat_q;
  assign WBm_BYTE_STB_o = sel_q;
  assign WBm_WE_o       = we_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;
  assign err_cnt_o      = err_cnt_q;

endmodule
